// File: rtl/muldiv_pkg.sv
// Shared types and op helpers for the iterative RV32M multiply/divide unit.
// Op encoding follows the RISC-V funct3 field of the M extension.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MULDIV_MUL    = 3'b000,
        MULDIV_MULH   = 3'b001,
        MULDIV_MULHSU = 3'b010,
        MULDIV_MULHU  = 3'b011,
        MULDIV_DIV    = 3'b100,
        MULDIV_DIVU   = 3'b101,
        MULDIV_REM    = 3'b110,
        MULDIV_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } muldiv_state_e;

    function automatic logic is_div(muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(muldiv_op_e op);
        return op inside {MULDIV_REM, MULDIV_REMU};
    endfunction

    function automatic logic is_signed_a(muldiv_op_e op);
        return op inside {MULDIV_MULH, MULDIV_MULHSU, MULDIV_DIV, MULDIV_REM};
    endfunction

    function automatic logic is_signed_b(muldiv_op_e op);
        return op inside {MULDIV_MULH, MULDIV_DIV, MULDIV_REM};
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
// hi/lo hold {product_hi, multiplier} or {remainder, quotient/dividend}.
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opd_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rs;
    logic [XLEN:0] diff;

    always_comb begin
        sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opd_i} : '0);
        rs   = {hi_i, lo_i[XLEN-1]};
        diff = rs - {1'b0, opd_i};
        if (div_i) begin
            if (!diff[XLEN]) begin
                hi_o = diff[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b1};
            end else begin
                hi_o = rs[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_o = sum[XLEN:1];
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready on both sides.
// Define MULDIV_EARLY_OUT_EN to finish trivial cases one edge after accept.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    muldiv_state_e   state_q, state_d;
    muldiv_op_e      op_q, op_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opd_q, opd_d;
    logic [XLEN-1:0] a_q, a_d;
    logic            neg_q, neg_d;
    logic            dz_q, dz_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] res_q, res_d;

    muldiv_op_e      op_in;
    logic            sa, sb;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN-1:0] core_hi, core_lo;

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   dval;
    logic [XLEN-1:0]   fix_res;

    assign op_in = muldiv_op_e'(op);
    assign sa    = is_signed_a(op_in) & A[XLEN-1];
    assign sb    = is_signed_b(op_in) & B[XLEN-1];
    assign a_mag = sa ? -A : A;
    assign b_mag = sb ? -B : B;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .div_i (is_div(op_q)),
        .hi_i  (hi_q),
        .lo_i  (lo_q),
        .opd_i (opd_q),
        .hi_o  (core_hi),
        .lo_o  (core_lo)
    );

    // Sign fix-up and result selection once all iterations are done.
    always_comb begin
        prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        dval = is_rem(op_q) ? hi_q : lo_q;
        if (neg_q) dval = -dval;
        if (is_div(op_q)) begin
            if (dz_q) fix_res = is_rem(op_q) ? a_q : '1;
            else      fix_res = dval;
        end else if (op_q == MULDIV_MUL) begin
            fix_res = prod[XLEN-1:0];
        end else begin
            fix_res = prod[2*XLEN-1:XLEN];
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opd_d   = opd_q;
        a_d     = a_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = op_in;
                    a_d     = A;
                    hi_d    = '0;
                    lo_d    = is_div(op_in) ? a_mag : b_mag;
                    opd_d   = is_div(op_in) ? b_mag : a_mag;
                    neg_d   = (is_rem(op_in)) ? sa : (sa ^ sb);
                    dz_d    = (B == '0);
                    cnt_d   = CNT_W'(XLEN);
                    state_d = CALC;
`ifdef MULDIV_EARLY_OUT_EN
                    if (is_div(op_in) && B == '0) begin
                        res_d   = is_rem(op_in) ? A : '1;
                        state_d = DONE;
                    end else if ((op_in inside {MULDIV_DIV, MULDIV_REM}) &&
                                 A == MIN_NEG && B == '1) begin
                        res_d   = (op_in == MULDIV_DIV) ? A : '0;
                        state_d = DONE;
                    end else if (!is_div(op_in) && (A == '0 || B == '0)) begin
                        res_d   = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    res_d   = fix_res;
                    state_d = DONE;
                end else begin
                    hi_d  = core_hi;
                    lo_d  = core_lo;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= MULDIV_MUL;
            hi_q    <= '0;
            lo_q    <= '0;
            opd_q   <= '0;
            a_q     <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opd_q   <= opd_d;
            a_q     <= a_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors plus random ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      op = '0;
    logic [XLEN-1:0] A = '0;
    logic [XLEN-1:0] B = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        logic [63:0]     p;
        int              ia = a;
        int              ib = b;
        bit              ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (o[2] && b == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == '1) return 1;
        if (!o[2] && (a == 0 || b == 0)) return 1;
`endif
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    task automatic start_op(input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b);
        @(negedge clock);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = o;
        A  = a;
        B  = b;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        op = 3'($urandom);
        A  = $urandom;
        B  = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
            if (!out_valid) out_ready = 1'($urandom_range(0, 1));
            else            out_ready = 1'b0;
        end while (!out_valid && lat < 200);
        if (!out_valid) check("timeout", 0, 1);
    endtask

    task automatic finish_op(input int stall);
        repeat (stall) @(posedge clock);
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit chk_lat);
        int lat;
        start_op(o, a, b);
        wait_done(lat);
        check(tag, result, exp);
        if (chk_lat) check({tag, "_lat"}, lat, exp_lat(o, a, b));
        finish_op(0);
    endtask

    initial begin
        int          lat;
        logic [2:0]  o;
        logic [31:0] a, b;

        #12;
        check("rst_inrdy", in_ready, 1);
        check("rst_ovld", out_valid, 0);
        check("rst_res", result, 0);
        @(negedge clock);
        reset = 1'b1;

        run("mul",    3'd0, 32'h0001_4C83, 32'hFFFE_8BB0, 32'h1C69_BB10, 1);
        run("mulh",   3'd1, 32'h0001_4C83, 32'hFFFE_8BB0, 32'hFFFF_FFFE, 1);
        run("mulhu",  3'd3, 32'h0001_4C83, 32'hFFFE_8BB0, 32'h0001_4C81, 1);
        run("mulhsu", 3'd2, 32'h0001_4C83, 32'hFFFE_8BB0, 32'h0001_4C81, 1);
        run("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1);
        run("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1);
        run("divu",   3'd5, 32'd100, 32'd7, 32'd14, 1);
        run("remu",   3'd7, 32'd100, 32'd7, 32'd2, 1);
        run("divu0",  3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
        run("remu0",  3'd7, 32'd100, 32'd0, 32'd100, 1);
        run("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run("mulz",   3'd1, 32'd0, 32'h1234_5678, 32'd0, 1);

        // Backpressure in DONE with a producer already waiting.
        start_op(3'd0, 32'h0001_4C83, 32'hFFFE_8BB0);
        wait_done(lat);
        check("bp_first", result, 32'h1C69_BB10);
        @(negedge clock);
        in_valid = 1'b1;
        op = 3'd5;
        A  = 32'd100;
        B  = 32'd7;
        repeat (5) begin
            @(posedge clock);
            #1;
            check("bp_ovld", out_valid, 1);
            check("bp_stable", result, 32'h1C69_BB10);
            check("bp_inrdy", in_ready, 0);
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check("bp_idle", in_ready, 1);
        check("bp_ovld_low", out_valid, 0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check("bp_accept", in_ready, 0);
        wait_done(lat);
        check("bp_second", result, 32'd14);
        check("bp_second_lat", lat + 1, exp_lat(3'd5, 32'd100, 32'd7) + 1);
        finish_op(0);

        // Reset in the middle of a divide.
        start_op(3'd4, 32'h7FFF_1234, 32'd3);
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_ovld", out_valid, 0);
        check("mid_rst_inrdy", in_ready, 1);
        check("mid_rst_res", result, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        run("post_rst_mul", 3'd0, 32'd3, 32'd5, 32'd15, 1);

        for (int i = 0; i < 2000; i++) begin
            o = 3'($urandom);
            a = pick();
            b = pick();
            start_op(o, a, b);
            wait_done(lat);
            check("rand", result, ref_res(o, a, b));
            check("rand_lat", lat, exp_lat(o, a, b));
            finish_op(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
